// File: rtl/bank_io_burst_unit_if.sv
// Scheduler-side command/data and DQ-side beat signals of the bank IO burst unit.
// rd_timeout exists only when READ_TIMEOUT_EN is defined.
interface bank_io_burst_unit_if #(
    parameter int DATA_WIDTH       = 64,
    parameter int DQ_WIDTH         = 16,
    parameter int RW_CONTROL_WIDTH = 2,
    localparam int BURST_LEN       = DATA_WIDTH / DQ_WIDTH,
    localparam int IO_CNT_WIDTH    = $clog2(BURST_LEN) + 1
);
    logic                        cmd_valid;
    logic                        cmd_is_write;
    logic                        cmd_ready;
    logic [DATA_WIDTH-1:0]       data_wr_phy;
    logic                        data_full_write_phy;
    logic [DQ_WIDTH-1:0]         dq_out;
    logic                        dq_oe;
    logic [DQ_WIDTH-1:0]         dq_in;
    logic                        dq_in_valid;
    logic [DATA_WIDTH-1:0]       data_read_phy;
    logic                        data_read_valid;
    logic [IO_CNT_WIDTH-1:0]     read_write_io_cnt;
    logic [RW_CONTROL_WIDTH-1:0] rw_control_state;
`ifdef READ_TIMEOUT_EN
    logic                        rd_timeout;
`endif

    modport slave (
        input  cmd_valid, cmd_is_write, data_wr_phy, dq_in, dq_in_valid,
        output cmd_ready, data_full_write_phy, dq_out, dq_oe,
               data_read_phy, data_read_valid, read_write_io_cnt, rw_control_state
`ifdef READ_TIMEOUT_EN
        , output rd_timeout
`endif
    );

    modport master (
        output cmd_valid, cmd_is_write, data_wr_phy, dq_in, dq_in_valid,
        input  cmd_ready, data_full_write_phy, dq_out, dq_oe,
               data_read_phy, data_read_valid, read_write_io_cnt, rw_control_state
`ifdef READ_TIMEOUT_EN
        , input rd_timeout
`endif
    );
endinterface

// File: rtl/bank_io_burst_unit.sv
// Purpose: serialize one write word onto DQ / deserialize read beats; READ_TIMEOUT_EN adds read abort.
// Latency: write beats start WL cycles after accept, done pulse one cycle after last beat; read word one cycle after last beat.
// Backpressure: one command at a time, cmd_ready only in IDLE; no beat-level backpressure on DQ.
module bank_io_burst_unit #(
    parameter int DATA_WIDTH       = 64,
    parameter int DQ_WIDTH         = 16,
    parameter int WL               = 2,
    parameter int RW_CONTROL_WIDTH = 2,
    parameter int RD_TIMEOUT       = 16,
    localparam int BURST_LEN       = DATA_WIDTH / DQ_WIDTH,
    localparam int IO_CNT_WIDTH    = $clog2(BURST_LEN) + 1
) (
    input  logic                   clk,
    input  logic                   power_on_rst_n,
    bank_io_burst_unit_if.slave    bus
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_WAIT  = 2'd1,
        WR_BURST = 2'd2,
        RD_BURST = 2'd3
    } state_t;

    localparam logic [IO_CNT_WIDTH-1:0] LAST_BEAT = IO_CNT_WIDTH'(BURST_LEN - 1);

    state_t                  state_q, state_d;
    logic [3:0]              wait_q;
    logic [IO_CNT_WIDTH-1:0] cnt_q;
    logic [DATA_WIDTH-1:0]   wr_sh_q;
    logic [DATA_WIDTH-1:0]   rd_sh_q;
    logic [DATA_WIDTH-1:0]   rd_word_q;
    logic [DATA_WIDTH-1:0]   rd_next;
    logic [DQ_WIDTH-1:0]     dq_out_q;
    logic                    dq_oe_q;
    logic                    cmd_ready_q;
    logic                    wr_done_q;
    logic                    rd_vld_q;
    logic                    accept, wait_done, wr_last, rd_beat, rd_last, rd_abort;

    assign accept    = bus.cmd_valid && cmd_ready_q;
    assign wait_done = (state_q == WR_WAIT) && (wait_q == 4'(WL - 1));
    assign wr_last   = (state_q == WR_BURST) && (cnt_q == LAST_BEAT);
    assign rd_beat   = (state_q == RD_BURST) && bus.dq_in_valid;
    assign rd_last   = rd_beat && (cnt_q == LAST_BEAT);
    // Beats shift in from the top, so after BURST_LEN beats the first one sits in the LSBs.
    assign rd_next   = (rd_sh_q >> DQ_WIDTH) | (DATA_WIDTH'(bus.dq_in) << (DATA_WIDTH - DQ_WIDTH));

`ifdef READ_TIMEOUT_EN
    localparam int TO_W = $clog2(RD_TIMEOUT + 1);
    logic [TO_W-1:0] idle_q;
    logic            to_pulse_q;

    assign rd_abort = (state_q == RD_BURST) && !bus.dq_in_valid &&
                      (idle_q == TO_W'(RD_TIMEOUT - 1));

    always_ff @(posedge clk or negedge power_on_rst_n) begin
        if (!power_on_rst_n) begin
            idle_q     <= '0;
            to_pulse_q <= 1'b0;
        end else begin
            to_pulse_q <= rd_abort;
            if (state_q != RD_BURST || bus.dq_in_valid)
                idle_q <= '0;
            else
                idle_q <= idle_q + 1'b1;
        end
    end

    assign bus.rd_timeout = to_pulse_q;
`else
    assign rd_abort = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (accept) state_d = bus.cmd_is_write ? WR_WAIT : RD_BURST;
            WR_WAIT:  if (wait_done) state_d = WR_BURST;
            WR_BURST: if (wr_last) state_d = IDLE;
            RD_BURST: if (rd_last || rd_abort) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge power_on_rst_n) begin
        if (!power_on_rst_n) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            wait_q      <= '0;
            cnt_q       <= '0;
            wr_sh_q     <= '0;
            rd_sh_q     <= '0;
            rd_word_q   <= '0;
            dq_out_q    <= '0;
            dq_oe_q     <= 1'b0;
            wr_done_q   <= 1'b0;
            rd_vld_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= (state_d == IDLE);
            wr_done_q   <= 1'b0;
            rd_vld_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        cnt_q  <= '0;
                        wait_q <= '0;
                        if (bus.cmd_is_write)
                            wr_sh_q <= bus.data_wr_phy;
                    end
                end
                WR_WAIT: begin
                    if (wait_done) begin
                        dq_oe_q  <= 1'b1;
                        dq_out_q <= wr_sh_q[DQ_WIDTH-1:0];
                        wr_sh_q  <= wr_sh_q >> DQ_WIDTH;
                    end else begin
                        wait_q <= wait_q + 4'd1;
                    end
                end
                WR_BURST: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (wr_last) begin
                        dq_oe_q   <= 1'b0;
                        dq_out_q  <= '0;
                        wr_done_q <= 1'b1;
                    end else begin
                        dq_out_q <= wr_sh_q[DQ_WIDTH-1:0];
                        wr_sh_q  <= wr_sh_q >> DQ_WIDTH;
                    end
                end
                RD_BURST: begin
                    if (rd_beat) begin
                        rd_sh_q <= rd_next;
                        cnt_q   <= cnt_q + 1'b1;
                        if (rd_last) begin
                            rd_word_q <= rd_next;
                            rd_vld_q  <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.cmd_ready           = cmd_ready_q;
    assign bus.data_full_write_phy = wr_done_q;
    assign bus.dq_out              = dq_out_q;
    assign bus.dq_oe               = dq_oe_q;
    assign bus.data_read_phy       = rd_word_q;
    assign bus.data_read_valid     = rd_vld_q;
    assign bus.read_write_io_cnt   = cnt_q;
    assign bus.rw_control_state    = RW_CONTROL_WIDTH'(state_q);
endmodule

// File: tb/tb_bank_io_burst_unit.sv
// Directed bench for bank_io_burst_unit: stimulus pushes expected DQ beats and pulses, a negedge monitor pops and compares.
module tb_bank_io_burst_unit;
    localparam int DW = 64, DQW = 16, WL = 2, BL = 4;
    localparam int K_BEAT = 0, K_FULL = 1, K_READ = 2, K_TO = 3;

    typedef struct {
        int          kind;
        logic [63:0] dat;
        int          cnt;
        int          cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc   = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    logic [15:0] wr_beats_a [4] = '{16'hCDEF, 16'h89AB, 16'h4567, 16'h0123};
    logic [15:0] wr_beats_b [4] = '{16'h3210, 16'h7654, 16'hBA98, 16'hFEDC};
    logic [15:0] rd_beats   [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bank_io_burst_unit_if #(.DATA_WIDTH(DW), .DQ_WIDTH(DQW)) bus ();

    bank_io_burst_unit #(.DATA_WIDTH(DW), .DQ_WIDTH(DQW), .WL(WL), .RD_TIMEOUT(16)) dut (
        .clk            (clk),
        .power_on_rst_n (rst_n),
        .bus            (bus)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input logic [63:0] dat, input int cnt, input int at);
        sb.push_back('{kind, dat, cnt, at});
    endtask

    task automatic sb_pop(input int kind, input logic [63:0] dat, input int cnt);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: kind %0d dat %h cnt %0d cycle %0d, nothing expected", kind, dat, cnt, cyc);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind || e.dat !== dat || e.cnt != cnt || e.cyc != cyc) begin
                errors++;
                $display("FAIL sb_event: got kind %0d dat %h cnt %0d cycle %0d, expected kind %0d dat %h cnt %0d cycle %0d",
                         kind, dat, cnt, cyc, e.kind, e.dat, e.cnt, e.cyc);
            end
        end
    endtask

    // Monitor: every DQ beat and every pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.dq_oe)
                sb_pop(K_BEAT, 64'(bus.dq_out), int'(bus.read_write_io_cnt));
            if (bus.data_full_write_phy)
                sb_pop(K_FULL, {47'd0, bus.dq_oe, bus.dq_out}, int'(bus.cmd_ready));
            if (bus.data_read_valid)
                sb_pop(K_READ, bus.data_read_phy, int'(bus.rw_control_state));
`ifdef READ_TIMEOUT_EN
            if (bus.rd_timeout)
                sb_pop(K_TO, 64'(bus.data_read_valid), int'(bus.rw_control_state));
`endif
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        int c;
        bus.cmd_valid    = 1'b0;
        bus.cmd_is_write = 1'b0;
        bus.data_wr_phy  = '0;
        bus.dq_in        = '0;
        bus.dq_in_valid  = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        chk("rst_dq_oe", 64'(bus.dq_oe), 64'd0);
        chk("rst_dq_out", 64'(bus.dq_out), 64'd0);
        chk("rst_state", 64'(bus.rw_control_state), 64'd0);
        chk("rst_io_cnt", 64'(bus.read_write_io_cnt), 64'd0);
        chk("rst_rd_data", bus.data_read_phy, 64'd0);
        chk("rst_pulses", {62'd0, bus.data_full_write_phy, bus.data_read_valid}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Write, then hold a read command through the whole write plus junk DQ input.
        bus.cmd_valid    = 1'b1;
        bus.cmd_is_write = 1'b1;
        bus.data_wr_phy  = 64'h0123_4567_89AB_CDEF;
        @(posedge clk); #1;
        a = cyc;
        for (int j = 0; j < BL; j++) push(K_BEAT, 64'(wr_beats_a[j]), j, a + WL + j);
        push(K_FULL, 64'd0, 1, a + WL + BL);
        bus.cmd_is_write = 1'b0;
        bus.data_wr_phy  = 64'hDEAD_BEEF_DEAD_BEEF;
        bus.dq_in        = 16'hDEAD;
        bus.dq_in_valid  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cyc == a + WL + BL) break;
            chk("busy_cmd_ready", 64'(bus.cmd_ready), 64'd0);
            chk("busy_state", 64'(bus.rw_control_state), (cyc >= a + WL) ? 64'd2 : 64'd1);
        end
        chk("done_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        chk("done_state", 64'(bus.rw_control_state), 64'd0);
        @(posedge clk); #1;
        bus.cmd_valid   = 1'b0;
        bus.dq_in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_state", 64'(bus.rw_control_state), 64'd3);
        chk("b2b_io_cnt", 64'(bus.read_write_io_cnt), 64'd0);

        // Read beats with one idle cycle between each.
        for (int k = 0; k < BL; k++) begin
            if (k > 0) @(negedge clk);
            bus.dq_in       = rd_beats[k];
            bus.dq_in_valid = 1'b1;
            if (k == BL - 1) push(K_READ, 64'h4444_3333_2222_1111, 0, cyc + 1);
            @(negedge clk);
            bus.dq_in_valid = 1'b0;
            bus.dq_in       = 16'hBAD0;
            if (k < BL - 1) chk("gap_io_cnt", 64'(bus.read_write_io_cnt), 64'(k + 1));
        end
        @(negedge clk);
        chk("rd_single_pulse", 64'(bus.data_read_valid), 64'd0);
        chk("rd_hold", bus.data_read_phy, 64'h4444_3333_2222_1111);

`ifdef READ_TIMEOUT_EN
        bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        bus.dq_in       = 16'hAAAA;
        bus.dq_in_valid = 1'b1;
        @(negedge clk);
        bus.dq_in = 16'hBBBB;
        c = cyc;
        push(K_TO, 64'd0, 0, c + 17);
        @(negedge clk);
        bus.dq_in_valid = 1'b0;
        repeat (20) @(negedge clk);
        chk("to_rd_hold", bus.data_read_phy, 64'h4444_3333_2222_1111);
        chk("to_state", 64'(bus.rw_control_state), 64'd0);
`endif

        // Reset asserted during the second write beat.
        bus.cmd_valid    = 1'b1;
        bus.cmd_is_write = 1'b1;
        bus.data_wr_phy  = 64'hFFFF_0000_A5A5_5A5A;
        @(posedge clk); #1;
        a = cyc;
        bus.cmd_valid = 1'b0;
        push(K_BEAT, 64'h5A5A, 0, a + WL);
        push(K_BEAT, 64'hA5A5, 1, a + WL + 1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cyc == a + WL + 1) break;
        end
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_dq_oe", 64'(bus.dq_oe), 64'd0);
        chk("mid_rst_dq_out", 64'(bus.dq_out), 64'd0);
        chk("mid_rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        chk("mid_rst_state", 64'(bus.rw_control_state), 64'd0);
        chk("mid_rst_rd_data", bus.data_read_phy, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("no_full_after_rst", 64'(bus.data_full_write_phy), 64'd0);
        end

        // Clean write after reset.
        bus.cmd_valid    = 1'b1;
        bus.cmd_is_write = 1'b1;
        bus.data_wr_phy  = 64'hFEDC_BA98_7654_3210;
        @(posedge clk); #1;
        a = cyc;
        bus.cmd_valid = 1'b0;
        for (int j = 0; j < BL; j++) push(K_BEAT, 64'(wr_beats_b[j]), j, a + WL + j);
        push(K_FULL, 64'd0, 1, a + WL + BL);
        repeat (WL + BL + 4) @(negedge clk);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
